// File: rtl/keypad_pkg.sv
// Shared keypad definitions: row drive patterns, scanner state encoding and the
// {col,row} active-low key codes consumed by the calculator key decoder.
package keypad_pkg;

  localparam logic [3:0] ROW0 = 4'b0111;
  localparam logic [3:0] ROW1 = 4'b1011;
  localparam logic [3:0] ROW2 = 4'b1101;
  localparam logic [3:0] ROW3 = 4'b1110;

  localparam logic [3:0] COL_IDLE  = 4'hF;
  localparam logic [7:0] IDLE_CODE = 8'hFF;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Key codes are {col,row}; col[3] is the leftmost column, row[3] the top row.
  localparam logic [7:0] KEY_1 = 8'h77;
  localparam logic [7:0] KEY_2 = 8'hB7;
  localparam logic [7:0] KEY_3 = 8'hD7;
  localparam logic [7:0] KEY_F = 8'hE7;
  localparam logic [7:0] KEY_4 = 8'h7B;
  localparam logic [7:0] KEY_5 = 8'hBB;
  localparam logic [7:0] KEY_6 = 8'hDB;
  localparam logic [7:0] KEY_E = 8'hEB;
  localparam logic [7:0] KEY_7 = 8'h7D;
  localparam logic [7:0] KEY_8 = 8'hBD;
  localparam logic [7:0] KEY_9 = 8'hDD;
  localparam logic [7:0] KEY_D = 8'hED;
  localparam logic [7:0] KEY_A = 8'h7E;
  localparam logic [7:0] KEY_0 = 8'hBE;
  localparam logic [7:0] KEY_B = 8'hDE;
  localparam logic [7:0] KEY_C = 8'hEE;

  // True when exactly one column is pulled low (a single, unambiguous key).
  function automatic logic one_cold(input logic [3:0] v);
    logic [2:0] zeros;
    zeros = 3'd0;
    for (int i = 0; i < 4; i++) begin
      zeros = zeros + {2'b00, ~v[i]};
    end
    return (zeros == 3'd1);
  endfunction

  function automatic logic [3:0] rotate_row(input logic [3:0] r);
    return {r[0], r[3:1]};
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Stable-run counter: raises done on the STABLE_CYCLES-th consecutive cycle of match.
// Any mismatch or clr restarts the run; the count saturates.
module keypad_debounce #(
  parameter int STABLE_CYCLES = 20000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic newClock,
  input  logic resetN,
  input  logic clr,
  input  logic match,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES);

  logic [CNT_W-1:0] cnt_r;

  // run-length register, restarted by clr or a broken run
  always_ff @(posedge newClock) begin
    if (!resetN) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr || !match) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != CNT_SAT) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // the current matching cycle completes the run when enough have gone before it
  always_comb begin
    done = 1'b0;
    if (match && (cnt_r >= CNT_LAST)) begin
      done = 1'b1;
    end else begin
      done = 1'b0;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce, presenting {col,row} codes.
// Optional build macro KEYPAD_SCANNER_SYNC_EN adds a 2-flop column synchronizer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       newClock,
  input  logic       resetN,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [7:0] values,
  output logic       keyValid,
  output logic       keyHeld
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);

  scan_state_t      state_r, state_s;
  logic [CNT_W-1:0] dwell_r, dwell_s;
  logic [3:0]       row_r, row_s;
  logic [7:0]       values_r, values_s;
  logic [7:0]       cand_r, cand_s;
  logic             keyvalid_r, keyvalid_s;
  logic             keyheld_r, keyheld_s;
  logic [3:0]       cols_s;
  logic             match_s, clr_s, done_s;

`ifdef KEYPAD_SCANNER_SYNC_EN
  logic [3:0] col_meta_r, col_sync_r;

  // two-flop synchronizer; idles released (all columns high)
  always_ff @(posedge newClock) begin
    if (!resetN) begin
      col_meta_r <= COL_IDLE;
      col_sync_r <= COL_IDLE;
    end else begin
      col_meta_r <= col;
      col_sync_r <= col_meta_r;
    end
  end

  assign cols_s = col_sync_r;
`else
  assign cols_s = col;
`endif

  // RELEASE counts all-high columns; DEBOUNCE counts the candidate's column pattern
  always_comb begin
    match_s = 1'b0;
    if (state_r == RELEASE) begin
      match_s = (cols_s == COL_IDLE);
    end else begin
      match_s = (cols_s == cand_r[7:4]);
    end
  end

  // The stable count only runs in DEBOUNCE/RELEASE and restarts on any state change.
  assign clr_s = (state_s != state_r) || (state_r == SCAN) || (state_r == PRESSED);

  keypad_debounce #(
    .STABLE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_debounce (
    .newClock (newClock),
    .resetN   (resetN),
    .clr      (clr_s),
    .match    (match_s),
    .done     (done_s)
  );

  // next-state and next-output decode
  always_comb begin
    state_s    = state_r;
    dwell_s    = {CNT_W{1'b0}};
    row_s      = row_r;
    values_s   = values_r;
    cand_s     = cand_r;
    keyvalid_s = 1'b0;
    keyheld_s  = keyheld_r;
    case (state_r)
      SCAN: begin
        if (dwell_r >= DWELL_LAST) begin
          if (one_cold(cols_s)) begin
            cand_s  = {cols_s, row_r};
            state_s = DEBOUNCE;
          end else begin
            row_s   = rotate_row(row_r);
            state_s = SCAN;
          end
        end else begin
          dwell_s = dwell_r + CNT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (!match_s) begin
          row_s   = rotate_row(row_r);
          state_s = SCAN;
        end else if (done_s) begin
          values_s   = cand_r;
          keyvalid_s = 1'b1;
          keyheld_s  = 1'b1;
          state_s    = PRESSED;
        end else begin
          state_s = DEBOUNCE;
        end
      end
      PRESSED: begin
        if (cols_s != cand_r[7:4]) begin
          state_s = RELEASE;
        end else begin
          state_s = PRESSED;
        end
      end
      RELEASE: begin
        // a return of the held key is bounce, not a new press
        if (cols_s == cand_r[7:4]) begin
          state_s = PRESSED;
        end else if (done_s) begin
          values_s  = IDLE_CODE;
          keyheld_s = 1'b0;
          row_s     = rotate_row(row_r);
          state_s   = SCAN;
        end else begin
          state_s = RELEASE;
        end
      end
      default: begin
        state_s   = SCAN;
        row_s     = ROW0;
        values_s  = IDLE_CODE;
        cand_s    = IDLE_CODE;
        keyheld_s = 1'b0;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge newClock) begin
    if (!resetN) begin
      state_r    <= SCAN;
      dwell_r    <= {CNT_W{1'b0}};
      row_r      <= ROW0;
      values_r   <= IDLE_CODE;
      cand_r     <= IDLE_CODE;
      keyvalid_r <= 1'b0;
      keyheld_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      dwell_r    <= dwell_s;
      row_r      <= row_s;
      values_r   <= values_s;
      cand_r     <= cand_s;
      keyvalid_r <= keyvalid_s;
      keyheld_r  <= keyheld_s;
    end
  end

  assign row      = row_r;
  assign values   = values_r;
  assign keyValid = keyvalid_r;
  assign keyHeld  = keyheld_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CYCLES=8); a keypad model
// drives col from row, expected codes are queued and popped on every keyValid strobe.
module tb_keypad_scanner;

`ifdef KEYPAD_SCANNER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       newClock;
  logic       resetN;
  logic [3:0] col;
  logic [3:0] row;
  logic [7:0] values;
  logic       keyValid;
  logic       keyHeld;

  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [7:0] exp_q[$];
  int         checks;
  int         failures;

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .newClock (newClock),
    .resetN   (resetN),
    .col      (col),
    .row      (row),
    .values   (values),
    .keyValid (keyValid),
    .keyHeld  (keyHeld)
  );

  // keypad model: the pressed key pulls its column low while its row is driven
  assign col = (row == key_row) ? key_col : 4'hF;

  initial newClock = 1'b0;
  always #5 newClock = ~newClock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic press(input logic [7:0] code);
    key_col = code[7:4];
    key_row = code[3:0];
  endtask

  task automatic release_key();
    key_row = 4'h0;
    key_col = 4'hF;
  endtask

  task automatic wait_row(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (row == target && n < 40) begin
      @(negedge newClock);
      n++;
    end
    while (row != target && n < 40) begin
      @(negedge newClock);
      n++;
    end
    check(name, {4'h0, row}, {4'h0, target});
  endtask

  task automatic wait_held(input string name);
    int n;
    n = 0;
    while (!keyHeld && n < 60) begin
      @(negedge newClock);
      n++;
    end
    check(name, {7'd0, keyHeld}, 8'h01);
  endtask

  // monitor: every keyValid strobe must match the oldest queued press
  initial begin
    logic [7:0] exp_code;
    forever begin
      @(negedge newClock);
      if (keyValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_keyvalid actual=%h required=no strobe", values);
        end else begin
          exp_code = exp_q.pop_front();
          check("keyvalid_code", values, exp_code);
          check("keyvalid_held", {7'd0, keyHeld}, 8'h01);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    resetN   = 1'b0;
    release_key();

    // 1: reset state and row rotation
    repeat (2) @(posedge newClock);
    @(negedge newClock);
    check("reset_row", {4'h0, row}, 8'h07);
    check("reset_values", values, 8'hFF);
    check("reset_keyvalid", {7'd0, keyValid}, 8'h00);
    check("reset_keyheld", {7'd0, keyHeld}, 8'h00);
    resetN = 1'b1;
    repeat (3) @(negedge newClock);
    check("dwell_row0", {4'h0, row}, 8'h07);
    @(negedge newClock);
    check("rotate_row1", {4'h0, row}, 8'h0B);

    // 2: press '5' for 40 cycles, then exact release latency
    exp_q.push_back(8'hBB);
    press(8'hBB);
    repeat (40) @(negedge newClock);
    check("press5_strobe_count", 8'(exp_q.size()), 8'h00);
    check("press5_values", values, 8'hBB);
    check("press5_held", {7'd0, keyHeld}, 8'h01);
    release_key();
    repeat (8 + SYNC_LAT) @(negedge newClock);
    check("release5_still_held", values, 8'hBB);
    @(negedge newClock);
    check("release5_values", values, 8'hFF);
    check("release5_held", {7'd0, keyHeld}, 8'h00);

    // 3: 3-cycle glitch on row 1011 covering the sample point
    wait_row(4'b1011, "glitch_reach_row1");
    @(negedge newClock);
    press(8'hBB);
    repeat (3) @(negedge newClock);
    release_key();
    wait_row(4'b1101, "glitch_scan_resumes");
    check("glitch_values", values, 8'hFF);
    check("glitch_held", {7'd0, keyHeld}, 8'h00);

    // 4: two columns low on the top row is ignored
    wait_row(4'b1110, "multi_reach_row3");
    key_row = 4'b0111;
    key_col = 4'b1001;
    wait_row(4'b0111, "multi_reach_row0");
    repeat (4) @(negedge newClock);
    check("multi_rotates", {4'h0, row}, 8'h0B);
    check("multi_values", values, 8'hFF);
    check("multi_held", {7'd0, keyHeld}, 8'h00);
    release_key();

    // 5: release bounce while 'C' is held
    exp_q.push_back(8'hEE);
    press(8'hEE);
    wait_held("pressC_held");
    key_col = 4'hF;
    repeat (3) @(negedge newClock);
    key_col = 4'hE;
    repeat (12) @(negedge newClock);
    check("bounceC_values", values, 8'hEE);
    check("bounceC_held", {7'd0, keyHeld}, 8'h01);
    release_key();
    repeat (12 + SYNC_LAT) @(negedge newClock);
    check("releaseC_values", values, 8'hFF);

    // 6: reset while '9' is pressed
    exp_q.push_back(8'hDD);
    press(8'hDD);
    wait_held("press9_held");
    check("press9_values", values, 8'hDD);
    resetN = 1'b0;
    release_key();
    @(negedge newClock);
    check("reset9_values", values, 8'hFF);
    check("reset9_held", {7'd0, keyHeld}, 8'h00);
    check("reset9_row", {4'h0, row}, 8'h07);
    check("reset9_keyvalid", {7'd0, keyValid}, 8'h00);
    resetN = 1'b1;
    repeat (20) @(negedge newClock);
    check("final_queue_empty", 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
